// File: rtl/cu_issue_sequencer_if.sv
// Handshake bundle between instruction fetch, the sequencer and the result consumer.
//   in_valid/in_ready/in_instr    : 16-bit instruction word, valid/ready
//   out_valid/out_ready/out_data/out_rd : written-back result and its destination index
// master = producer/consumer side (fetch + writeback sink), slave = sequencer.
interface cu_issue_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_rd;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );
endinterface

// File: rtl/cu_issue_sequencer.sv
// Issues one instruction at a time to a combinational CU and writes the result
// back into a 4x8-bit register file.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : instruction in / result out handshakes (slave modport)
//   cu_op        : op to CU, 0 outside ISSUE
//   cu_operand1/2: operands to CU, 0 outside ISSUE and for LI
//   cu_result    : combinational CU result, sampled at the end of ISSUE
//   busy         : high in ISSUE and WB
module cu_issue_sequencer #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    cu_issue_sequencer_if.slave         bus,
    output logic [2:0]                  cu_op,
    output logic [7:0]                  cu_operand1,
    output logic [7:0]                  cu_operand2,
    input  logic [7:0]                  cu_result,
    output logic                        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    state_t     r_state, w_next;
    logic [7:0] r_rf [4];
    logic [2:0] r_op;
    logic [1:0] r_rd;
    logic [7:0] r_opnd1, r_opnd2, r_imm;
    logic [7:0] r_out_data;
    logic [1:0] r_out_rd;

    logic       w_accept;
    logic       w_li;
    logic [7:0] w_result;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_li     = (bus.in_instr[15:13] == 3'b000);
    // LI bypasses the CU entirely; cu_result is only meaningful for op 1..7.
    assign w_result = (r_op == 3'b000) ? r_imm : cu_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WB;
            S_WB:    if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: CU port is forced quiet outside ISSUE
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        cu_op         = 3'b000;
        cu_operand1   = 8'h00;
        cu_operand2   = 8'h00;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
            end
            S_ISSUE: begin
                cu_op       = r_op;
                cu_operand1 = r_opnd1;
                cu_operand2 = r_opnd2;
            end
            S_WB:    bus.out_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign bus.out_data = r_out_data;
    assign bus.out_rd   = r_out_rd;

    // Datapath: operands read at acceptance, writeback at the edge ending ISSUE.
    // Reset wins over both, so an in-flight instruction never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_rf[i] <= REG_INIT;
            r_op       <= 3'b000;
            r_rd       <= 2'b00;
            r_opnd1    <= 8'h00;
            r_opnd2    <= 8'h00;
            r_imm      <= 8'h00;
            r_out_data <= 8'h00;
            r_out_rd   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_op    <= bus.in_instr[15:13];
                r_rd    <= bus.in_instr[12:11];
                r_imm   <= bus.in_instr[7:0];
                r_opnd1 <= w_li ? 8'h00 : r_rf[bus.in_instr[10:9]];
                r_opnd2 <= w_li ? 8'h00 : r_rf[bus.in_instr[8:7]];
            end
            if (r_state == S_ISSUE) begin
                r_rf[r_rd] <= w_result;
                r_out_data <= w_result;
                r_out_rd   <= r_rd;
            end
        end
    end
endmodule

// File: tb/tb_cu_issue_sequencer.sv
module tb_cu_issue_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cu_op;
    logic [7:0] cu_operand1, cu_operand2, cu_result;
    logic       busy;

    cu_issue_sequencer_if bus();

    cu_issue_sequencer #(.REG_INIT(8'h11)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cu_op       (cu_op),
        .cu_operand1 (cu_operand1),
        .cu_operand2 (cu_operand2),
        .cu_result   (cu_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Bench-side CU: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 inc, 7 add+1
    function automatic logic [7:0] cu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a + 8'd1;
            3'd7:    return a + b + 8'd1;
            default: return 8'h00;
        endcase
    endfunction
    assign cu_result = cu_model(cu_op, cu_operand1, cu_operand2);

    typedef struct packed { logic [2:0] op; logic [7:0] a; logic [7:0] b; } iss_t;
    typedef struct packed { logic [1:0] rd; logic [7:0] d; } out_t;
    iss_t iss_q[$];
    out_t out_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [6:0] lo);
        return {op, rd, rs1, rs2, lo};
    endfunction

    function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b000, rd, 3'b000, imm};
    endfunction

    // Issue-cycle monitor: ISSUE is the only busy state without out_valid
    always @(negedge clk) begin
        if (busy && !bus.out_valid) begin
            if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
            else begin
                iss_t e;
                e = iss_q.pop_front();
                chk("issue_op", cu_op, e.op);
                chk("issue_opnd1", cu_operand1, e.a);
                chk("issue_opnd2", cu_operand2, e.b);
            end
        end else begin
            chk("idle_quiet", {cu_op, cu_operand1, cu_operand2}, 0);
        end
    end

    // Result monitor: compares at every completed output transfer
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (out_q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                out_t e;
                e = out_q.pop_front();
                chk("out_rd", bus.out_rd, e.rd);
                chk("out_data", bus.out_data, e.d);
            end
        end
    end

    // Presents w until accepted (bounded), then pushes the expectations.
    task automatic send(input logic [15:0] w, input iss_t ei, input bit has_out, input out_t eo);
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = bus.in_ready && !rst;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        else begin
            iss_q.push_back(ei);
            if (has_out) out_q.push_back(eo);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && !bus.in_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!bus.in_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_instr  = li(2'd0, 8'hEE);
        bus.out_ready = 1'b1;

        // Reset, with an instruction presented that must not be taken
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cu_op", cu_op, 0);
        chk("rst_opnds", {cu_operand1, cu_operand2}, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_rd", bus.out_rd, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // LI then ALU
        send(li(2'd0, 8'h05), iss_t'{3'd0, 8'h00, 8'h00}, 1, out_t'{2'd0, 8'h05});
        wait_idle();
        send(li(2'd1, 8'h03), iss_t'{3'd0, 8'h00, 8'h00}, 1, out_t'{2'd1, 8'h03});
        wait_idle();
        send(enc(3'd1, 2'd2, 2'd0, 2'd1, 7'h00), iss_t'{3'd1, 8'h05, 8'h03}, 1, out_t'{2'd2, 8'h08});
        chk("lat_issue_busy", busy, 1);
        chk("lat_issue_noval", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("lat_wb_valid", bus.out_valid, 1);
        chk("lat_wb_rd", bus.out_rd, 2);
        chk("lat_wb_data", bus.out_data, 8'h08);
        wait_idle();

        // Backpressure with a second word held on the input
        bus.out_ready = 1'b0;
        send(enc(3'd3, 2'd0, 2'd0, 2'd1, 7'h00), iss_t'{3'd3, 8'h05, 8'h03}, 1, out_t'{2'd0, 8'h01});
        bus.in_valid = 1'b1;
        bus.in_instr = li(2'd2, 8'h77);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", bus.out_data, 8'h01);
            chk("bp_out_rd", bus.out_rd, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);

        // Read-after-write, rd = rs1 = rs2
        send(li(2'd3, 8'hAA), iss_t'{3'd0, 8'h00, 8'h00}, 1, out_t'{2'd3, 8'hAA});
        wait_idle();
        send(enc(3'd7, 2'd3, 2'd3, 2'd3, 7'h00), iss_t'{3'd7, 8'hAA, 8'hAA}, 1, out_t'{2'd3, 8'h55});
        wait_idle();
        send(enc(3'd1, 2'd0, 2'd3, 2'd0, 7'h00), iss_t'{3'd1, 8'h55, 8'h01}, 1, out_t'{2'd0, 8'h56});
        wait_idle();

        // Reset during ISSUE: no result, registers back to REG_INIT
        send(enc(3'd2, 2'd1, 2'd0, 2'd1, 7'h00), iss_t'{3'd2, 8'h56, 8'h03}, 0, out_t'{2'd0, 8'h00});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", busy, 0);
        send(enc(3'd1, 2'd2, 2'd1, 2'd1, 7'h00), iss_t'{3'd1, 8'h11, 8'h11}, 1, out_t'{2'd2, 8'h22});
        wait_idle();

        // Reserved bits ignored
        send(enc(3'd5, 2'd3, 2'd2, 2'd1, 7'h00), iss_t'{3'd5, 8'h22, 8'h11}, 1, out_t'{2'd3, 8'h33});
        wait_idle();
        send(enc(3'd5, 2'd3, 2'd2, 2'd1, 7'h7F), iss_t'{3'd5, 8'h22, 8'h11}, 1, out_t'{2'd3, 8'h33});
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("iss_q_drained", iss_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
